arith_arbiter: RTL and testbench
================================

# arith_arbiter

Sequencing arbiter sharing one gate-level 32-bit arithmetic unit between two requesters.
- Accepts operation requests (ADD, SUB, NEG, INC) on two valid/ready ports and grants one at a time.
- Drives the unit's operand and function inputs, plus the effective sign bits for the status unit.
- Holds those inputs stable for a programmable settle window, then captures the 32-bit result and 4-bit status (V,Z,N,C) into a response register held under a valid/ready handshake.
- Sits between the register/control logic and the combinational arithmetic datapath.

## Interface
- SETTLE_CYCLES, 4, clock cycles operands are held before capture; legal range 1..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  operands A, B
- req0_op / req1_op  in  2  00 ADD A+B, 01 SUB A-B, 10 NEG -B, 11 INC B+1
- au_a, au_b  out  32  operands to arithmetic unit
- au_f1, au_f0  out  1  function select (= op[1], op[0])
- au_sign_a, au_sign_b  out  1  effective operand signs to status unit
- au_s  in  32  unit sum
- au_status  in  4  {V,Z,N,C} from status unit
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_id  out  1  port that issued the operation
- resp_result  out  32  captured sum
- resp_status  out  4  captured {V,Z,N,C}
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, no valid request: stay in IDLE.
- IDLE, any valid request: grant exactly one port.
  - Assert that port's ready combinationally.
  - At the edge, register a/b/op into au_a/au_b/au_f1/au_f0 and the port number into resp_id.
  - Load cnt = SETTLE_CYCLES-1 and go to WAIT.
- Arbitration is round-robin:
  - A 1-bit pointer names the preferred port.
  - When both ports are valid, the preferred port wins.
  - After any grant, the pointer moves to the other port.
  - With only one port valid, that port wins regardless of the pointer.
- WAIT, cnt != 0: cnt decrements each edge.
- WAIT, cnt == 0: at the edge, capture au_s into resp_result and au_status into resp_status, and go to RESP.
- RESP: resp_valid=1. If resp_ready=1, return to IDLE at the edge. No new grant occurs in RESP.
- au_sign_a = op[1] ? 0 : a[31].
- au_sign_b = (op==01 || op==10) ? ~b[31] : b[31].
- The status unit therefore evaluates overflow on the operands actually summed.
- au_* outputs change only on a grant edge and are otherwise held.
- req*_ready is 0 in WAIT and RESP.
- Requesters must hold valid and operands until ready. The block samples them only on the grant edge.
- Reset at any time, including mid-operation:
  - Abort the in-flight operation; no response is issued.
  - State goes to IDLE, the pointer to port 0, and every output register to 0.

## Timing
- Reset values: req*_ready=0, au_a=au_b=0, au_f1=au_f0=0, au_sign_a=au_sign_b=0, resp_valid=0, resp_id=0, resp_result=0, resp_status=0, busy=0.
- Latency: if grant edge is E, the capture edge is E+SETTLE_CYCLES and resp_valid is high from that edge.
- Minimum issue interval: SETTLE_CYCLES+2 cycles (resp_ready held 1).
- SETTLE_CYCLES=1: capture on the first edge after the grant.
- Clock period × SETTLE_CYCLES must exceed the unit's worst-case ripple settle time. This is checked in verification, not by the block.
- resp_* outputs are stable while resp_valid=1 and resp_ready=0.

## Configuration
- ARITH_ARB_FIXED_PRIO_EN defined: fixed priority. Port 0 always wins a simultaneous request and the pointer logic is removed.
- Macro undefined (default): round-robin as above.

## Test plan
- ADD A=64, B=-64 on port 0, SETTLE_CYCLES=4 → resp_valid 4 edges after grant, resp_result=0, resp_status=0101, resp_id=0.
- SUB A=5, B=7 on port 1 → resp_result=0xFFFFFFFE, resp_status=0010, au_sign_b=1 during WAIT.
- ADD A=0x7FFFFFFF, B=1 → resp_result=0x80000000, resp_status=1010. NEG B=0 → result 0, status 0101.
- Both ports continuously valid with INC ops, resp_ready=1 → grants alternate 0,1,0,1, and each grant is spaced SETTLE_CYCLES+2 cycles apart. With ARITH_ARB_FIXED_PRIO_EN, every grant goes to port 0.
- Hold resp_ready=0 for 10 cycles in RESP → resp_* stable, both readies 0, port 1 stays pending. Release → port 1 is granted in the next IDLE cycle.
- Assert rst_n=0 in the 2nd WAIT cycle → all outputs 0 immediately and no resp_valid. After release, a new ADD 1+2 → result 3, status 0000.

Source files
------------

// File: rtl/arith_arbiter_if.sv
// Request, arithmetic-unit and response signals of arith_arbiter.
// slave = arbiter side, master = requesters, arithmetic unit and response consumer.
interface arith_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  req1_op;
    logic [31:0] au_a;
    logic [31:0] au_b;
    logic        au_f1;
    logic        au_f0;
    logic        au_sign_a;
    logic        au_sign_b;
    logic [31:0] au_s;
    logic [3:0]  au_status;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic [3:0]  resp_status;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output au_a, au_b, au_f1, au_f0, au_sign_a, au_sign_b,
        input  au_s, au_status,
        output resp_valid, resp_id, resp_result, resp_status, busy,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  au_a, au_b, au_f1, au_f0, au_sign_a, au_sign_b,
        output au_s, au_status,
        input  resp_valid, resp_id, resp_result, resp_status, busy,
        output resp_ready
    );
endinterface

// File: rtl/arith_arbiter.sv
// Two-port arbiter sharing one arithmetic unit; round-robin, or fixed port-0 priority with ARITH_ARB_FIXED_PRIO_EN.
// Latency: grant edge + SETTLE_CYCLES to resp_valid; back-to-back issue every SETTLE_CYCLES+2 cycles.
// Backpressure: response held stable until resp_ready; no request is accepted while busy.
module arith_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    arith_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_op;

`ifdef ARITH_ARB_FIXED_PRIO_EN
    assign gnt1 = bus.req1_valid && !bus.req0_valid;
`else
    logic rr_ptr;
    assign gnt1 = bus.req1_valid && (rr_ptr || !bus.req0_valid);
`endif
    assign gnt0    = bus.req0_valid && !gnt1;
    assign gnt_any = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = gnt_any && gnt0;
    assign bus.req1_ready = gnt_any && gnt1;
    assign bus.busy       = (state != IDLE);

    assign sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
    assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.au_a        <= '0;
            bus.au_b        <= '0;
            bus.au_f1       <= 1'b0;
            bus.au_f0       <= 1'b0;
            bus.au_sign_a   <= 1'b0;
            bus.au_sign_b   <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_id     <= 1'b0;
            bus.resp_result <= '0;
            bus.resp_status <= '0;
`ifndef ARITH_ARB_FIXED_PRIO_EN
            rr_ptr          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        bus.au_a      <= sel_a;
                        bus.au_b      <= sel_b;
                        bus.au_f1     <= sel_op[1];
                        bus.au_f0     <= sel_op[0];
                        // Signs of the operands the adder really sums: A is dropped for NEG/INC, B inverted for SUB/NEG.
                        bus.au_sign_a <= sel_op[1] ? 1'b0 : sel_a[31];
                        bus.au_sign_b <= (sel_op == 2'b01 || sel_op == 2'b10) ? ~sel_b[31] : sel_b[31];
                        bus.resp_id   <= gnt1;
                        cnt           <= CNT_INIT;
                        state         <= WAIT;
`ifndef ARITH_ARB_FIXED_PRIO_EN
                        rr_ptr        <= ~gnt1;
`endif
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        bus.resp_result <= bus.au_s;
                        bus.resp_status <= bus.au_status;
                        bus.resp_valid  <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_arbiter.sv
// Randomized and directed bench for arith_arbiter with a transaction-level reference model
// and a stand-in ripple arithmetic/status unit.
module tb_arith_arbiter;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rnd_done = 1'b0;

    arith_arbiter_if bus ();

    arith_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in arithmetic unit: operands as summed, plus {V,Z,N,C} from the effective signs.
    logic [31:0] au_x, au_y;
    logic [32:0] au_sum;
    always_comb begin
        au_x   = bus.au_f1 ? 32'd0 : bus.au_a;
        au_y   = (bus.au_f1 ^ bus.au_f0) ? ~bus.au_b : bus.au_b;
        au_sum = {1'b0, au_x} + {1'b0, au_y} + 33'(bus.au_f1 | bus.au_f0);
        bus.au_s      = au_sum[31:0];
        bus.au_status = {(bus.au_sign_a == bus.au_sign_b) && (au_sum[31] != bus.au_sign_a),
                         au_sum[31:0] == 32'd0, au_sum[31], au_sum[32]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference arithmetic from true integer values: {V,Z,N,C,result}.
    function automatic logic [35:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sv;
        logic [31:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00:   begin r = a + b; c = (longint'(a) + longint'(b)) > 64'sd4294967295; sv = sa + sb; end
            2'b01:   begin r = a - b; c = (a >= b);                                       sv = sa - sb; end
            2'b10:   begin r = -b;    c = (b == 32'd0);                                    sv = -sb;     end
            default: begin r = b + 1; c = (b == 32'hFFFF_FFFF);                            sv = sb + 1;  end
        endcase
        v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        return {v, r == 32'd0, r[31], c, r};
    endfunction

    // Transaction-level model state
    bit          m_idle, m_rv, m_ptr, m_id, m_f1, m_f0, m_sa, m_sb;
    int          m_age, mw;
    logic [31:0] m_a, m_b, m_res, p_res;
    logic [3:0]  m_stat, p_stat;

    task model_reset();
        m_idle = 1; m_rv = 0; m_ptr = 0; m_id = 0; m_age = 0;
        m_a = 0; m_b = 0; m_f1 = 0; m_f0 = 0; m_sa = 0; m_sb = 0;
        m_res = 0; m_stat = 0;
    endtask

    function automatic int winner();
        if (!bus.req0_valid && !bus.req1_valid) return -1;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ARITH_ARB_FIXED_PRIO_EN
            return 0;
`else
            return int'(m_ptr);
`endif
        end
        return bus.req0_valid ? 0 : 1;
    endfunction

    task model_step(input int w);
        logic [31:0] a, b;
        logic [1:0]  op;
        if (m_idle) begin
            if (w >= 0) begin
                a  = (w == 0) ? bus.req0_a  : bus.req1_a;
                b  = (w == 0) ? bus.req0_b  : bus.req1_b;
                op = (w == 0) ? bus.req0_op : bus.req1_op;
                m_a = a; m_b = b; m_f1 = op[1]; m_f0 = op[0];
                m_sa = op[1] ? 1'b0 : a[31];
                m_sb = (op == 2'b01 || op == 2'b10) ? ~b[31] : b[31];
                m_id = (w == 1);
                {p_stat, p_res} = ref_op(op, a, b);
                m_ptr = (w == 0);
                m_age = 0;
                m_idle = 0;
            end
        end else if (!m_rv) begin
            m_age++;
            if (m_age == S) begin
                m_rv = 1; m_res = p_res; m_stat = p_stat;
            end
        end else if (bus.resp_ready) begin
            m_rv = 0;
            m_idle = 1;
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        mw = winner();
        chk("ready0",      bus.req0_ready,  rst_n && m_idle && mw == 0);
        chk("ready1",      bus.req1_ready,  rst_n && m_idle && mw == 1);
        chk("au_a",        bus.au_a,        m_a);
        chk("au_b",        bus.au_b,        m_b);
        chk("au_f",        {bus.au_f1, bus.au_f0}, {m_f1, m_f0});
        chk("au_signs",    {bus.au_sign_a, bus.au_sign_b}, {m_sa, m_sb});
        chk("resp_valid",  bus.resp_valid,  m_rv);
        chk("resp_id",     bus.resp_id,     m_id);
        chk("resp_result", bus.resp_result, m_res);
        chk("resp_status", bus.resp_status, m_stat);
        chk("busy",        bus.busy,        !m_idle);
        if (rst_n) model_step(mw);
    end

    // Grant log observed at the DUT
    int gq_id[$];
    int gq_cyc[$];
    always @(negedge clk) begin
        if (rst_n && bus.req0_ready) begin gq_id.push_back(0); gq_cyc.push_back(cyc); end
        if (rst_n && bus.req1_ready) begin gq_id.push_back(1); gq_cyc.push_back(cyc); end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int port, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int gcyc);
        if (port == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end
        gcyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((port == 0) ? bus.req0_ready : bus.req1_ready) begin
                gcyc = cyc + 1;
                break;
            end
        end
        if (gcyc < 0) fail("issue_grant");
        step();
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic wait_resp(output int rcyc);
        rcyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                rcyc = cyc;
                break;
            end
        end
        if (rcyc < 0) fail("resp_valid_wait");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},  {bus.req0_ready, bus.req1_ready}, 2'b00);
        chk({tag, "_au_a"},   bus.au_a, 32'd0);
        chk({tag, "_au_b"},   bus.au_b, 32'd0);
        chk({tag, "_au_ctl"}, {bus.au_f1, bus.au_f0, bus.au_sign_a, bus.au_sign_b}, 4'd0);
        chk({tag, "_resp"},   {bus.resp_valid, bus.resp_id, bus.resp_status}, 6'd0);
        chk({tag, "_result"}, bus.resp_result, 32'd0);
        chk({tag, "_busy"},   bus.busy, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_port(input int port, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            issue(port, 2'($urandom_range(0, 3)), pick(), pick(), g);
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    initial begin
        int g, r, ok;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.resp_ready = 1'b1;

        chk("model_add_cancel", ref_op(2'b00, 32'd64, -32'sd64), {4'b0101, 32'd0});
        chk("model_inc_wrap",   ref_op(2'b11, 32'd0, 32'h7FFF_FFFF), {4'b1010, 32'h8000_0000});

        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // ADD 64 + -64 on port 0
        issue(0, 2'b00, 32'd64, 32'hFFFF_FFC0, g);
        wait_resp(r);
        chk("add_latency", r - g, S);
        chk("add_result",  bus.resp_result, 32'd0);
        chk("add_status",  bus.resp_status, 4'b0101);
        chk("add_id",      bus.resp_id, 1'b0);
        step();

        // SUB 5 - 7 on port 1
        issue(1, 2'b01, 32'd5, 32'd7, g);
        chk("sub_sign_b_wait", bus.au_sign_b, 1'b1);
        wait_resp(r);
        chk("sub_result", bus.resp_result, 32'hFFFF_FFFE);
        chk("sub_status", bus.resp_status, 4'b0010);
        chk("sub_id",     bus.resp_id, 1'b1);
        step();

        // Signed overflow on ADD, then NEG of zero
        issue(0, 2'b00, 32'h7FFF_FFFF, 32'd1, g);
        wait_resp(r);
        chk("ovf_result", bus.resp_result, 32'h8000_0000);
        chk("ovf_status", bus.resp_status, 4'b1010);
        step();
        issue(1, 2'b10, 32'd9, 32'd0, g);
        wait_resp(r);
        chk("neg0_result", bus.resp_result, 32'd0);
        chk("neg0_status", bus.resp_status, 4'b0101);
        step();

        // Both ports continuously valid with INC
        gq_id.delete(); gq_cyc.delete();
        bus.req0_op = 2'b11; bus.req0_b = 32'd10; bus.req0_a = 32'd0; bus.req0_valid = 1'b1;
        bus.req1_op = 2'b11; bus.req1_b = 32'd20; bus.req1_a = 32'd0; bus.req1_valid = 1'b1;
        for (int i = 0; i < 200 && gq_id.size() < 4; i++) step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        if (gq_id.size() < 4) fail("alt_grants");
        else begin
            for (int i = 0; i < 4; i++) begin
`ifdef ARITH_ARB_FIXED_PRIO_EN
                chk("fixed_grant_id", gq_id[i], 0);
`else
                chk("rr_grant_id", gq_id[i], i % 2);
`endif
                if (i > 0) chk("grant_spacing", gq_cyc[i] - gq_cyc[i-1], S + 2);
            end
        end
        wait_resp(r);
        step();

        // Response held under backpressure while port 1 waits
        bus.resp_ready = 1'b0;
        bus.req0_op = 2'b00; bus.req0_a = 32'd100; bus.req0_b = 32'd23; bus.req0_valid = 1'b1;
        bus.req1_op = 2'b01; bus.req1_a = 32'd1;   bus.req1_b = 32'd1;  bus.req1_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin ok = 1; break; end
        end
        if (ok == 0) fail("hold_grant0");
        step();
        bus.req0_valid = 1'b0;
        wait_resp(r);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_result", bus.resp_result, 32'd123);
            chk("hold_status", {bus.resp_valid, bus.resp_id, bus.resp_status}, {1'b1, 1'b0, 4'b0000});
            chk("hold_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        step();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_grant1", bus.req1_ready, 1'b1);
        step();
        bus.req1_valid = 1'b0;
        wait_resp(r);
        chk("port1_result", bus.resp_result, 32'd0);
        chk("port1_status", {bus.resp_id, bus.resp_status}, {1'b1, 4'b0101});
        step();

        // Reset during the second WAIT cycle
        issue(0, 2'b00, 32'd5, 32'd6, g);
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < S + 4; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", bus.resp_valid, 1'b0);
        end
        step();
        issue(0, 2'b00, 32'd1, 32'd2, g);
        wait_resp(r);
        chk("post_rst_result", bus.resp_result, 32'd3);
        chk("post_rst_status", bus.resp_status, 4'b0000);
        step();

        // Randomized traffic with random response backpressure
        fork
            begin
                while (!rnd_done) begin
                    step();
                    bus.resp_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join_none
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        rnd_done = 1'b1;
        step();
        bus.resp_ready = 1'b1;
        repeat (S + 6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
